// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// Runs one operation at a time: PREP computes operand magnitudes and catches
// the divide special cases, CALC runs ITERS radix-2 steps (shift-add multiply
// or restoring divide), and FIN presents the sign-corrected, registered result.
// Ports:
//   clk, reset_n         clock and synchronous active-low reset
//   start, kill          request a new operation / abort the current one
//   funct3, op_a, op_b   operation select and source operands (rs1, rs2)
//   rd_in                destination register index
//   busy, done           operation in flight / one-cycle completion pulse
//   result, rd_out       writeback value and destination index (held after done)
//   we_out               register-file write enable (done && rd_out != 0)
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [5:0]      LAST_STEP = 6'(ITERS - 1);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        fn;
  logic [XLEN-1:0]   opa_lat;
  logic [XLEN-1:0]   opb_lat;
  logic [4:0]        rd_lat;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dsor;      // multiplicand or divisor magnitude
  logic [5:0]        cnt;
  logic              neg_main;  // product or quotient must be negated
  logic              neg_rem;   // remainder must be negated

  logic              sgn_a_en;
  logic              sgn_b_en;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              is_div;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_mag;
  logic [XLEN-1:0]   rem_mag;
  logic [XLEN-1:0]   fin_val;

  assign is_div   = fn[2];
  assign neg_a    = sgn_a_en & opa_lat[XLEN-1];
  assign neg_b    = sgn_b_en & opb_lat[XLEN-1];
  assign mag_a    = neg_a ? ({XLEN{1'b0}} - opa_lat) : opa_lat;
  assign mag_b    = neg_b ? ({XLEN{1'b0}} - opb_lat) : opb_lat;
  assign div_zero = is_div && (opb_lat == {XLEN{1'b0}});
  // Only the signed forms (DIV/REM, funct3[0]=0) can overflow.
  assign div_ovf  = is_div && !fn[0] && (opa_lat == INT_MIN) && (opb_lat == ALL_ONES);

  // Which operands are interpreted as signed for the latched operation.
  always_comb begin
    sgn_a_en = 1'b0;
    sgn_b_en = 1'b0;
    case (fn)
      3'b001:         begin sgn_a_en = 1'b1; sgn_b_en = 1'b1; end
      3'b010:         begin sgn_a_en = 1'b1; sgn_b_en = 1'b0; end
      3'b100, 3'b110: begin sgn_a_en = 1'b1; sgn_b_en = 1'b1; end
      default:        begin sgn_a_en = 1'b0; sgn_b_en = 1'b0; end
    endcase
  end

  // Fixed results for divide-by-zero and signed overflow, which skip CALC.
  always_comb begin
    special_val = {XLEN{1'b0}};
    if (div_zero) begin
      special_val = fn[1] ? opa_lat : ALL_ONES;
    end else begin
      special_val = fn[1] ? {XLEN{1'b0}} : INT_MIN;
    end
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    acc_next = acc;
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dsor} : {(XLEN+1){1'b0}});
    // Trial subtract of the divisor from {remainder, next dividend bit}.
    diff = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {2'b00, dsor};
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and output selection applied to the final step.
  always_comb begin
    prod    = neg_main ? ({(2*XLEN){1'b0}} - acc_next) : acc_next;
    quo_mag = acc_next[XLEN-1:0];
    rem_mag = acc_next[2*XLEN-1:XLEN];
    case (fn)
      3'b000:                 fin_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
      3'b100:                 fin_val = neg_main ? ({XLEN{1'b0}} - quo_mag) : quo_mag;
      3'b101:                 fin_val = quo_mag;
      3'b110:                 fin_val = neg_rem ? ({XLEN{1'b0}} - rem_mag) : rem_mag;
      3'b111:                 fin_val = rem_mag;
      default:                fin_val = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      fn       <= 3'd0;
      opa_lat  <= {XLEN{1'b0}};
      opb_lat  <= {XLEN{1'b0}};
      rd_lat   <= 5'd0;
      acc      <= {(2*XLEN){1'b0}};
      dsor     <= {XLEN{1'b0}};
      cnt      <= 6'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we_out   <= 1'b0;
      result   <= {XLEN{1'b0}};
      rd_out   <= 5'd0;
    end else if (kill) begin
      // Abort: result and rd_out keep whatever the last completed op left.
      state  <= S_IDLE;
      acc    <= {(2*XLEN){1'b0}};
      cnt    <= 6'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done   <= 1'b0;
          we_out <= 1'b0;
          if (start) begin
            state   <= S_PREP;
            busy    <= 1'b1;
            fn      <= funct3;
            opa_lat <= op_a;
            opb_lat <= op_b;
            rd_lat  <= rd_in;
          end
        end
        S_PREP: begin
          acc      <= {{XLEN{1'b0}}, mag_a};
          dsor     <= mag_b;
          cnt      <= 6'd0;
          neg_main <= neg_a ^ neg_b;
          neg_rem  <= neg_a;
          if (div_zero || div_ovf) begin
            result <= special_val;
            rd_out <= rd_lat;
            done   <= 1'b1;
            we_out <= (rd_lat != 5'd0);
            state  <= S_FIN;
          end else begin
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            result <= fin_val;
            rd_out <= rd_lat;
            done   <= 1'b1;
            we_out <= (rd_lat != 5'd0);
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          we_out <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          we_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random operations are issued, each
// accepted operation pushes its expected result, destination, write enable and
// completion cycle into a queue, and a monitor pops and compares on every done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned up;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 34;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
    end
  endtask

  // Present one start pulse at a negedge while idle; optionally score it.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit push);
    exp_t e;
    wait_idle();
    funct3 = f; op_a = a; op_b = b; rd_in = r; start = 1'b1;
    if (push) begin
      e.res = model(f, a, b);
      e.rd  = r;
      e.we  = (r != 5'd0);
      e.due = cyc + latency(f, a, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: result %h rd %0d with nothing outstanding", result, rd_out);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        check("we_out", 32'(we_out), 32'(e.we));
        check("done_cycle", cyc, e.due);
        last_res = e.res;
        last_rd  = e.rd;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] edges [8];
    logic [31:0] a, b;
    int n;
    edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF; edges[5] = 32'h8000_0001;
    edges[6] = 32'h0000_0002; edges[7] = 32'hFFFF_FFFE;

    reset_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_we",     32'(we_out), 32'd0);
    check("reset_result", result,      32'd0);
    check("reset_rd",     32'(rd_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed operations from the test plan.
    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  1'b1);
    issue(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  1'b1);
    issue(3'd2, 32'h8000_0000,  32'h8000_0000, 5'd7,  1'b1);
    issue(3'd3, 32'h8000_0000,  32'h8000_0000, 5'd8,  1'b1);
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  1'b1);
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 1'b1);
    issue(3'd5, 32'd100,        32'd7,         5'd11, 1'b1);
    issue(3'd7, 32'd100,        32'd7,         5'd12, 1'b1);
    issue(3'd5, 32'h1234_5678,  32'd0,         5'd13, 1'b1);
    issue(3'd6, 32'd13,         32'd0,         5'd14, 1'b1);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 1'b1);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 1'b1);
    issue(3'd4, 32'd13,         32'd0,         5'd17, 1'b1);
    issue(3'd0, 32'd3,          32'd9,         5'd0,  1'b1);
    wait_idle();

    // Kill at CALC cycle 10: no done, outputs keep the previous op's values.
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20, 1'b0);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy",   32'(busy),   32'd0);
    check("kill_done",   32'(done),   32'd0);
    check("kill_result", result,      last_res);
    check("kill_rd",     32'(rd_out), 32'(last_rd));
    repeat (40) @(negedge clk);
    check("kill_no_late_done", 32'(busy), 32'd0);
    issue(3'd5, 32'd1000, 32'd33, 5'd21, 1'b1);

    // kill together with start is not accepted.
    wait_idle();
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd22; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_over_start_busy", 32'(busy), 32'd0);

    // Reset mid-CALC clears every output.
    issue(3'd1, 32'hF000_0001, 32'h0F0F_0F0F, 5'd23, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_we",     32'(we_out), 32'd0);
    check("rst_result", result,      32'd0);
    check("rst_rd",     32'(rd_out), 32'd0);
    reset_n = 1'b1;
    last_res = 32'd0; last_rd = 5'd0;
    issue(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd24, 1'b1);

    // start held while busy with changing operands is ignored.
    wait_idle();
    funct3 = 3'd4; op_a = 32'hFFFF_FC18; op_b = 32'd9; rd_in = 5'd25; start = 1'b1;
    sb_q.push_back('{model(3'd4, 32'hFFFF_FC18, 32'd9), 5'd25, 1'b1, cyc + 34});
    n = 0;
    do begin
      @(negedge clk);
      funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      n++;
    end while (!done && n < 100);
    start = 1'b0;
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL held_start: no done within %0d cycles", n);
    end

    // Randomized operations, biased toward boundary operands.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      issue(3'($urandom), a, b, 5'($urandom), 1'b1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("outstanding_ops", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
